// File: rtl/csa_acc_pkg.sv
// Shared types and elaboration helpers for the carry-save streaming accumulator.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } acc_state_e;

    // Number of resolve cycles: one ripple slice per cycle.
    function automatic int unsigned calc_k(input int unsigned acc_w, input int unsigned chunk_w);
        return acc_w / chunk_w;
    endfunction

    // Legal configuration: whole number of slices and room for a full operand.
    function automatic bit cfg_ok(input int unsigned data_w, input int unsigned acc_w,
                                  input int unsigned chunk_w);
        return (chunk_w != 0) && ((acc_w % chunk_w) == 0) && (acc_w >= data_w);
    endfunction

endpackage

// File: rtl/csa_acc_if.sv
// Operand (producer) and result (consumer) valid/ready channels of csa_accumulator.
interface csa_acc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 12
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/csa_accumulator_rca_chunk.sv
// Parametrised CHUNK_W-bit ripple-carry adder slice built from full-adder cells.
module rca_chunk #(
    parameter int unsigned CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);

    logic [CHUNK_W:0] cy;

    assign cy[0] = cin;

    for (genvar i = 0; i < CHUNK_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
    end

    assign cout = cy[CHUNK_W];

endmodule

// File: rtl/csa_accumulator.sv
// Streaming carry-save multi-operand accumulator with a chunked multi-cycle final adder.
// Optional overflow sticky / out_ovf reporting: define CSA_ACC_OVF_EN.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned CHUNK_W = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    csa_acc_if.slave bus
);

    localparam int unsigned K     = calc_k(ACC_W, CHUNK_W);
    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

    if (!cfg_ok(DATA_W, ACC_W, CHUNK_W)) begin : g_cfg_bad
        $error("csa_accumulator: ACC_W must be a multiple of CHUNK_W and >= DATA_W");
    end

    acc_state_e         state;
    logic [ACC_W-1:0]   s_q;
    logic [ACC_W-1:0]   c_q;
    logic [ACC_W-1:0]   sum_q;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               accept;
    logic               last_chunk;
    logic [ACC_W-1:0]   op;
    logic [ACC_W-1:0]   s_next;
    logic [ACC_W-1:0]   c_next;
    logic [CHUNK_W-1:0] chunk_a;
    logic [CHUNK_W-1:0] chunk_b;
    logic [CHUNK_W-1:0] chunk_sum;
    logic               chunk_cout;

    assign accept     = bus.in_valid & in_ready_q;
    assign last_chunk = (idx == IDX_W'(K - 1));
    assign op         = ACC_W'(bus.in_data);
    assign s_next     = s_q ^ c_q ^ op;

`ifdef CSA_ACC_OVF_EN
    logic [ACC_W-1:0] maj;
    assign maj    = (s_q & c_q) | (s_q & op) | (c_q & op);
    assign c_next = {maj[ACC_W-2:0], 1'b0};
`else
    // The top majority bit only feeds overflow, so it is not formed at all here.
    logic [ACC_W-2:0] maj_lo;
    assign maj_lo = (s_q[ACC_W-2:0] & c_q[ACC_W-2:0]) |
                    (s_q[ACC_W-2:0] & op[ACC_W-2:0])  |
                    (c_q[ACC_W-2:0] & op[ACC_W-2:0]);
    assign c_next = {maj_lo, 1'b0};
`endif

    assign chunk_a = s_q[32'(idx) * CHUNK_W +: CHUNK_W];
    assign chunk_b = c_q[32'(idx) * CHUNK_W +: CHUNK_W];

    rca_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_rca_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Control FSM with compress datapath and chunk-by-chunk resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            sum_q       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        s_q <= s_next;
                        c_q <= c_next;
                        if (bus.in_last) begin
                            state      <= RESOLVE;
                            in_ready_q <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                RESOLVE: begin
                    sum_q[32'(idx) * CHUNK_W +: CHUNK_W] <= chunk_sum;
                    if (last_chunk) begin
                        idx         <= '0;
                        carry       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        carry <= chunk_cout;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        s_q         <= '0;
                        c_q         <= '0;
                        idx         <= '0;
                        carry       <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSA_ACC_OVF_EN
    logic sticky;
    logic ovf_q;

    // Sticky collects carries dropped by compression plus the final resolve carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if ((state == IDLE || state == ACCUM) && accept) begin
                sticky <= sticky | maj[ACC_W-1];
            end else if (state == RESOLVE && last_chunk) begin
                sticky <= sticky | chunk_cout;
                ovf_q  <= sticky | chunk_cout;
            end else if (state == OUT && bus.out_ready) begin
                sticky <= 1'b0;
            end
        end
    end

    assign bus.out_ovf = ovf_q;
`else
    assign bus.out_ovf = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;

endmodule
